self_draw: RTL and testbench
============================

SELF_DRAW -- requirements
Module: self_draw

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, sole clock, rising edge.
REQ-002 The block SHALL have the port `reset_n`: input, 1 bit, synchronous, active-low reset.
REQ-003 The block SHALL have the port `self_enable`: input, 1 bit, draw request from the player controller.
REQ-004 The block SHALL have the port `op`: input, 2 bits, drawing operation.
- 00: draw ship.
- 01: erase ship and bullet.
- 10: draw ship and bullet.
- 11: no-op.
REQ-005 The block SHALL have the port `x`: input, 8 bits, left column of the ship.
REQ-006 The block SHALL have the port `vga_x`: output, 8 bits, pixel column to the VGA adapter.
REQ-007 The block SHALL have the port `vga_y`: output, 7 bits, pixel row to the VGA adapter.
REQ-008 The block SHALL have the port `colour`: output, 3 bits, pixel colour.
REQ-009 The block SHALL have the port `plot`: output, 1 bit, pixel write strobe.
REQ-010 The block SHALL have the port `busy`: output, 1 bit, high while an operation is in progress.
REQ-011 The block SHALL have the port `done`: output, 1 bit, one-cycle pulse at the end of an operation.

Function
REQ-012 The FSM SHALL have four states: IDLE, SHIP, FIRE, FIN.
REQ-013 In IDLE, when `self_enable`=1 on a clock edge, the block SHALL latch `op` and `x`, set `busy`=1, and enter SHIP, or enter FIN directly if op=11.
REQ-014 While `busy`=1, the block SHALL ignore `self_enable`, `op` and `x`; latched values are used until FIN.
REQ-015 SHIP SHALL scan 32 cells, one per cycle, row-major: row r=0..3, column c=0..7, with vga_x=x+c and vga_y=112+r.
REQ-016 Ship shape: row 0 SHALL contain only c=3 and c=4; rows 1-3 SHALL be full.
REQ-017 For op 00/10, `plot` SHALL be 1 only on shape cells, with colour=3'b111.
REQ-018 For op 01, `plot` SHALL be 1 on all 32 cells, with colour=3'b000.
REQ-019 After cell 31, the block SHALL enter FIN for op 00, or FIRE for op 01/10.
REQ-020 FIRE SHALL scan 12 cells, one per cycle, with vga_x=x+3 and vga_y=100..111 ascending; colour SHALL be 3'b100 for op 10 and 3'b000 for op 01; `plot`=1.
REQ-021 Clipping: any cell with x+c>159 (computed in 9 bits, no wrap) SHALL have `plot`=0; the scan counter still advances.
REQ-022 In FIN, the block SHALL pulse `done`=1 for one cycle, clear `busy`, and return to IDLE.
REQ-023 Latency, with the request accepted at edge T:
- First cell at T+1.
- op 00: done at T+33.
- op 01/10: done at T+45.
- op 11: done at T+1.
REQ-024 `self_enable` high in the same cycle as `done` SHALL NOT be accepted; acceptance SHALL occur only in IDLE, i.e. the earliest restart is one cycle after FIN.
REQ-025 `vga_x`, `vga_y` and `colour` SHALL be registered; `plot` SHALL be aligned with them in the same cycle.

Reset
REQ-026 While `reset_n`=0 at a clock edge, the FSM SHALL go to IDLE and clear all counters.
REQ-027 Under the same condition, all outputs SHALL be 0, including mid-operation, with no `done` pulse.
REQ-028 After reset release, the block SHALL accept a request on the first edge with `self_enable`=1.

Structure
REQ-029 A shared package SHALL hold the following constants:
- Op encodings.
- SHIP_Y=112, SHIP_W=8, SHIP_H=4.
- FIRE_Y0=100, FIRE_LEN=12, FIRE_COL=3.
- X_MAX=159.
- Colours: WHITE, RED, BLACK.
- The FSM state typedef.
REQ-030 One sub-module, `sprite_scan`, SHALL be used: a loadable row/column counter providing cell index, (c,r) and a last-cell flag, reused for both SHIP and FIRE.

Verification
REQ-031 x=82, op=00, enable 1 cycle: 26 plots over T+1..T+32, all colour 7, first at (85,112), done at T+33.
REQ-032 x=20, op=10: 26 white ship plots, then 12 red plots at (23,100..111), done at T+45.
REQ-033 x=155, op=01: in each ship row, columns 155..159 plot and 160..162 are suppressed; the bullet column at 158 plots; done at T+45.
REQ-034 op=11: done at T+1, `plot` never asserted; a second request during `busy` on a 00 operation is ignored, giving exactly one done.
REQ-035 Reset asserted at T+10 of an op 10 operation: at the next edge all outputs are 0 and the FSM is in IDLE; a new op 00 then completes normally.

Source files
------------

// File: rtl/self_draw_pkg.sv
// self_draw shared package
// op codes, geometry, colours, fsm state type
package self_draw_pkg;

  localparam logic [1:0] OP_SHIP  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_FIRE  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam int SHIP_Y   = 112;
  localparam int SHIP_W   = 8;
  localparam int SHIP_H   = 4;
  localparam int FIRE_Y0  = 100;
  localparam int FIRE_LEN = 12;
  localparam int FIRE_COL = 3;
  localparam int X_MAX    = 159;

  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIP,
    S_FIRE,
    S_FIN
  } state_t;

  // ship outline: nose is two pixels wide
  function automatic logic ship_cell(
    input logic [2:0] c,
    input logic [3:0] r
  );
    return (r != 4'd0) || (c == 3'd3) || (c == 3'd4);
  endfunction

endpackage

// File: rtl/self_draw_sprite_scan.sv
// sprite_scan: loadable row-major cell counter
// shared by ship and bullet scans
module sprite_scan
  import self_draw_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       step,
  input  logic [2:0] ld_cmax,
  input  logic [3:0] ld_rmax,
  output logic [2:0] col,
  output logic [3:0] row,
  output logic [5:0] idx,
  output logic       last
);

  logic [2:0] c_q, c_d;
  logic [3:0] r_q, r_d;
  logic [5:0] idx_q, idx_d;
  logic [2:0] cmax_q, cmax_d;
  logic [3:0] rmax_q, rmax_d;

  // next cell: load restarts, step walks columns then rows
  always_comb begin
    c_d    = c_q;
    r_d    = r_q;
    idx_d  = idx_q;
    cmax_d = cmax_q;
    rmax_d = rmax_q;
    if (load) begin
      c_d    = 3'd0;
      r_d    = 4'd0;
      idx_d  = 6'd0;
      cmax_d = ld_cmax;
      rmax_d = ld_rmax;
    end else if (step) begin
      idx_d = idx_q + 6'd1;
      if (c_q == cmax_q) begin
        c_d = 3'd0;
        r_d = r_q + 4'd1;
      end else begin
        c_d = c_q + 3'd1;
      end
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_q    <= 3'd0;
      r_q    <= 4'd0;
      idx_q  <= 6'd0;
      cmax_q <= 3'd0;
      rmax_q <= 4'd0;
    end else begin
      c_q    <= c_d;
      r_q    <= r_d;
      idx_q  <= idx_d;
      cmax_q <= cmax_d;
      rmax_q <= rmax_d;
    end
  end

  assign col  = c_q;
  assign row  = r_q;
  assign idx  = idx_q;
  assign last = (c_q == cmax_q) && (r_q == rmax_q);

endmodule

// File: rtl/self_draw.sv
// self_draw: player ship / bullet pixel painter
// one registered pixel per cycle to the vga adapter
module self_draw
  import self_draw_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       self_enable,
  input  logic [1:0] op,
  input  logic [7:0] x,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] x_q, x_d;
  logic [7:0] vx_q, vx_d;
  logic [6:0] vy_q, vy_d;
  logic [2:0] col_q, col_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       sc_load;
  logic       sc_step;
  logic [2:0] sc_ld_cmax;
  logic [3:0] sc_ld_rmax;
  logic [2:0] sc_c;
  logic [3:0] sc_r;
  logic [5:0] sc_idx;
  logic       sc_last;

  logic [8:0] xs;
  logic       clip;

  sprite_scan u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (sc_load),
    .step    (sc_step),
    .ld_cmax (sc_ld_cmax),
    .ld_rmax (sc_ld_rmax),
    .col     (sc_c),
    .row     (sc_r),
    .idx     (sc_idx),
    .last    (sc_last)
  );

  // column of the current cell, 9 bits so it cannot wrap
  always_comb begin
    xs = {1'b0, x_q} + {6'd0, sc_c};
    if (state_q == S_FIRE) begin
      xs = {1'b0, x_q} + 9'(FIRE_COL);
    end
    clip = (xs > 9'(X_MAX));
  end

  // fsm next state and next pixel
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    vx_d       = 8'd0;
    vy_d       = 7'd0;
    col_d      = BLACK;
    plot_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sc_load    = 1'b0;
    sc_step    = 1'b0;
    sc_ld_cmax = 3'd0;
    sc_ld_rmax = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (self_enable && !done_q) begin
          op_d   = op;
          x_d    = x;
          busy_d = 1'b1;
          if (op == OP_NOP) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_SHIP;
            sc_load    = 1'b1;
            sc_ld_cmax = 3'(SHIP_W - 1);
            sc_ld_rmax = 4'(SHIP_H - 1);
          end
        end
      end
      S_SHIP: begin
        sc_step = 1'b1;
        vx_d    = xs[7:0];
        vy_d    = 7'(SHIP_Y) + {3'd0, sc_r};
        if (op_q == OP_ERASE) begin
          col_d  = BLACK;
          plot_d = !clip;
        end else begin
          col_d  = WHITE;
          plot_d = ship_cell(sc_c, sc_r) && !clip;
        end
        if (sc_last) begin
          if (op_q == OP_SHIP) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_FIRE;
            sc_load    = 1'b1;
            sc_ld_cmax = 3'd0;
            sc_ld_rmax = 4'(FIRE_LEN - 1);
          end
        end
      end
      S_FIRE: begin
        sc_step = 1'b1;
        vx_d    = xs[7:0];
        vy_d    = 7'(FIRE_Y0) + {1'b0, sc_idx};
        col_d   = (op_q == OP_FIRE) ? RED : BLACK;
        plot_d  = !clip;
        if (sc_last) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      x_q     <= 8'd0;
      vx_q    <= 8'd0;
      vy_q    <= 7'd0;
      col_q   <= 3'd0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vga_x  = vx_q;
  assign vga_y  = vy_q;
  assign colour = col_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_self_draw.sv
// tb_self_draw: table vectors, random ops vs model,
// busy-ignore and mid-op reset sequences
module tb_self_draw;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       self_enable;
  logic [1:0] op;
  logic [7:0] x;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  self_draw dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .self_enable (self_enable),
    .op          (op),
    .x           (x),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int vx;
    int vy;
    int col;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    int x;
    int plots;
    int lat;
    int fx;
    int fy;
  } vec_t;

  exp_t exp_q[$];

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, req, $time);
    end
  endtask

  // expected pixel stream, one entry per cycle after acceptance
  task automatic build_model(input logic [1:0] o, input int xv);
    exp_t e;
    exp_q.delete();
    if (o == 2'b11) return;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        bit in_shape = (r > 0) || (c == 3) || (c == 4);
        bit vis = (xv + c) <= 159;
        e.vx  = (xv + c) % 256;
        e.vy  = 112 + r;
        e.col = (o == 2'b01) ? 0 : 7;
        e.p   = (o == 2'b01) ? int'(vis) : int'(vis && in_shape);
        exp_q.push_back(e);
      end
    end
    if (o == 2'b00) return;
    for (int i = 0; i < 12; i++) begin
      e.vx  = (xv + 3) % 256;
      e.vy  = 100 + i;
      e.col = (o == 2'b10) ? 4 : 0;
      e.p   = int'((xv + 3) <= 159);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_op(
    input  logic [1:0] o,
    input  int         xv,
    output int         plots,
    output int         lat,
    output int         fx,
    output int         fy
  );
    int L;
    exp_t e;
    build_model(o, xv);
    L = exp_q.size();
    @(negedge clk);
    self_enable = 1'b1;
    op = o;
    x  = xv[7:0];
    @(posedge clk);
    #1;
    self_enable = 1'b0;
    op = 2'($urandom);
    x  = 8'($urandom);
    check("busy_on_accept", int'(busy), 1);
    plots = 0;
    lat = -1;
    fx = -1;
    fy = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        self_enable = 1'b1;
      end else begin
        self_enable = 1'b0;
      end
      if (plot) begin
        plots++;
        if (fx < 0) begin
          fx = int'(vga_x);
          fy = int'(vga_y);
        end
      end
      if (k <= L) begin
        e = exp_q[k-1];
        check("plot", int'(plot), e.p);
        if (e.p != 0) begin
          check("vga_x", int'(vga_x), e.vx);
          check("vga_y", int'(vga_y), e.vy);
          check("colour", int'(colour), e.col);
        end
        check("busy_scan", int'(busy), 1);
        check("done_early", int'(done), 0);
      end else if (k == L + 1) begin
        check("done_pulse", int'(done), 1);
        check("busy_clear", int'(busy), 0);
        check("plot_fin", int'(plot), 0);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    self_enable = 1'b0;
    @(posedge clk);
    #1;
    check("done_one_cycle", int'(done), 0);
  endtask

  vec_t vecs[6];

  initial begin
    int pl, lt, fx, fy;
    int dones, first;
    logic [1:0] ro;
    int rx;

    vecs[0] = '{2'b00, 82, 26, 33, 85, 112};
    vecs[1] = '{2'b10, 20, 38, 45, 23, 112};
    vecs[2] = '{2'b01, 155, 32, 45, 155, 112};
    vecs[3] = '{2'b11, 0, 0, 1, -1, -1};
    vecs[4] = '{2'b00, 152, 26, 33, 155, 112};
    vecs[5] = '{2'b10, 157, 9, 45, 157, 113};

    reset_n = 1'b0;
    self_enable = 1'b0;
    op = 2'b00;
    x = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_vx", int'(vga_x), 0);
    check("rst_vy", int'(vga_y), 0);
    check("rst_col", int'(colour), 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].x, pl, lt, fx, fy);
      check($sformatf("vec%0d_plots", i), pl, vecs[i].plots);
      check($sformatf("vec%0d_lat", i), lt, vecs[i].lat);
      check($sformatf("vec%0d_fx", i), fx, vecs[i].fx);
      check($sformatf("vec%0d_fy", i), fy, vecs[i].fy);
    end

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = int'($urandom_range(0, 255));
      build_model(ro, rx);
      run_op(ro, rx, pl, lt, fx, fy);
      check("rand_lat", lt, exp_q.size() + 1);
    end

    @(negedge clk);
    self_enable = 1'b1;
    op = 2'b00;
    x = 8'd10;
    @(posedge clk);
    #1;
    self_enable = 1'b0;
    dones = 0;
    first = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (first < 0) first = k;
      end
      if (k == 34) check("busy_after_fin", int'(busy), 0);
      self_enable = ((k >= 3) && (k <= 8)) || done;
      op = (k <= 8) ? 2'b10 : 2'b11;
    end
    self_enable = 1'b0;
    check("ignore_dones", dones, 1);
    check("ignore_lat", first, 33);

    @(negedge clk);
    self_enable = 1'b1;
    op = 2'b10;
    x = 8'd40;
    @(posedge clk);
    #1;
    self_enable = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_plot", int'(plot), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_vx", int'(vga_x), 0);
    check("mid_rst_vy", int'(vga_y), 0);
    check("mid_rst_col", int'(colour), 0);
    @(posedge clk);
    #1;
    check("mid_rst_done2", int'(done), 0);
    reset_n = 1'b1;
    run_op(2'b00, 60, pl, lt, fx, fy);
    check("post_rst_lat", lt, 33);
    check("post_rst_plots", pl, 26);
    check("post_rst_fx", fx, 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
